// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with step, branch, load and call/return stack.
// Define PC_TRAP_EN to vector to TRAP_ADDR on stack overflow/underflow.
module pc_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter logic [ADDR_W-1:0] INC_STEP    = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] TRAP_ADDR   = '1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               pc_load,
  input  logic [ADDR_W-1:0]                  load_addr,
  input  logic                               pc_inc,
  input  logic                               branch_rel,
  input  logic [ADDR_W-1:0]                  rel_offset,
  input  logic                               call,
  input  logic                               ret,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err,
  output logic                               trap
);

  localparam int SP_W = $clog2(STACK_DEPTH+1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic              sel_ret, sel_call, sel_load;
  logic              sel_br, sel_inc;
  logic              push, err_ev;
  logic              full, empty;
  logic [ADDR_W-1:0] ret_addr, pop_val;

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign ret_addr = pc_q + INC_STEP;

  // one-hot winner: ret > call > pc_load > branch_rel > pc_inc
  assign sel_ret  = ret;
  assign sel_call = call & ~ret;
  assign sel_load = pc_load & ~call & ~ret;
  assign sel_br   = branch_rel & ~pc_load & ~call & ~ret;
  assign sel_inc  = pc_inc & ~branch_rel & ~pc_load
                  & ~call & ~ret;

  always_comb begin
    pop_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) pop_val = stack_q[i];
    end
  end

  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    err_d  = err_q;
    push   = 1'b0;
    err_ev = 1'b0;
    if (en) begin
      unique case (1'b1)
        sel_ret: begin
          if (empty) begin
            err_ev = 1'b1;
          end else begin
            pc_d = pop_val;
            sp_d = sp_q - SP_W'(1);
          end
        end
        sel_call: begin
          if (full) begin
            err_ev = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = load_addr;
            sp_d = sp_q + SP_W'(1);
          end
        end
        sel_load: pc_d = load_addr;
        sel_br:   pc_d = pc_q + rel_offset;
        sel_inc:  pc_d = pc_q + INC_STEP;
        default:  ;
      endcase
    end
    if (err_ev) err_d = 1'b1;
`ifdef PC_TRAP_EN
    if (err_ev) pc_d = TRAP_ADDR;
`endif
  end

  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (push && sp_q == SP_W'(i)) stack_d[i] = ret_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

`ifdef PC_TRAP_EN
  logic trap_q, trap_d;

  assign trap_d = err_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign trap = trap_q;
`else
  logic [ADDR_W-1:0] trap_addr_unused;
  assign trap_addr_unused = TRAP_ADDR;
  assign trap             = 1'b0;
`endif

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random stimulus against a queue-based
// reference model of the PC sequencer (default build, no trap).
module tb_pc_sequencer;

  logic       clk, rst_n, en;
  logic       pc_load, pc_inc, branch_rel, call, ret;
  logic [7:0] load_addr, rel_offset;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full, stack_empty, stack_err, trap;

  int n_vec = 0;
  int n_err = 0;

  int mpc;
  int stk[$];
  bit merr;

  pc_sequencer #(
    .ADDR_W(8),
    .STACK_DEPTH(4),
    .RESET_ADDR(8'h10),
    .INC_STEP(8'h01),
    .TRAP_ADDR(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pc_load(pc_load),
    .load_addr(load_addr),
    .pc_inc(pc_inc),
    .branch_rel(branch_rel),
    .rel_offset(rel_offset),
    .call(call),
    .ret(ret),
    .pc(pc),
    .sp(sp),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .stack_err(stack_err),
    .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    mpc  = 'h10;
    stk  = {};
    merr = 1'b0;
  endtask

  task automatic model_step();
    if (!en) return;
    if (ret) begin
      if (stk.size() == 0) merr = 1'b1;
      else mpc = stk.pop_back();
    end else if (call) begin
      if (stk.size() == 4) begin
        merr = 1'b1;
      end else begin
        stk.push_back((mpc + 1) % 256);
        mpc = load_addr;
      end
    end else if (pc_load) begin
      mpc = load_addr;
    end else if (branch_rel) begin
      mpc = (mpc + rel_offset) % 256;
    end else if (pc_inc) begin
      mpc = (mpc + 1) % 256;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, mpc);
    check({tag, ".sp"}, sp, stk.size());
    check({tag, ".full"}, stack_full, stk.size() == 4);
    check({tag, ".empty"}, stack_empty, stk.size() == 0);
    check({tag, ".err"}, stack_err, merr);
    check({tag, ".trap"}, trap, 1'b0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic go(input string tag, input bit e, input bit ld,
                    input bit inc, input bit br, input bit cl,
                    input bit rt, input logic [7:0] la,
                    input logic [7:0] off);
    en = e; pc_load = ld; pc_inc = inc; branch_rel = br;
    call = cl; ret = rt; load_addr = la; rel_offset = off;
    step(tag);
  endtask

  // reset asserted between edges; checked before any clock edge
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; pc_load = 0; pc_inc = 0; branch_rel = 0;
    call = 0; ret = 0; load_addr = 0; rel_offset = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    go("inc1", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    go("inc2", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    go("inc3", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    check("inc3.val", pc, 8'h13);
    mid_reset("midrst");
    check("midrst.val", pc, 8'h10);

    go("ldFE", 1, 1, 0, 0, 0, 0, 8'hFE, 8'h00);
    go("wrap1", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    go("wrap2", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    check("wrap.val", pc, 8'h00);
    go("ld02", 1, 1, 0, 0, 0, 0, 8'h02, 8'h00);
    go("brneg", 1, 0, 0, 1, 0, 0, 8'h00, 8'hFC);
    check("brneg.val", pc, 8'hFE);

    go("ld20", 1, 1, 0, 0, 0, 0, 8'h20, 8'h00);
    go("call40", 1, 0, 0, 0, 1, 0, 8'h40, 8'h00);
    go("call60", 1, 0, 0, 0, 1, 0, 8'h60, 8'h00);
    go("ret1", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("ret1.val", pc, 8'h41);
    go("ret2", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("ret2.val", pc, 8'h21);

    for (int i = 0; i < 5; i++)
      go("deep", 1, 0, 0, 0, 1, 0, 8'hA0 + 8'(i), 8'h00);
    check("ovf.pc", pc, 8'hA3);
    check("ovf.err", stack_err, 1'b1);

    mid_reset("rst2");
    go("unf", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("unf.err", stack_err, 1'b1);
    go("sticky1", 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    go("sticky2", 1, 0, 0, 0, 1, 0, 8'h77, 8'h00);
    check("sticky.err", stack_err, 1'b1);

    mid_reset("rst3");
    go("ld30", 1, 1, 0, 0, 0, 0, 8'h30, 8'h00);
    go("call50", 1, 0, 0, 0, 1, 0, 8'h50, 8'h00);
    go("prio", 1, 1, 1, 0, 1, 1, 8'h99, 8'h00);
    check("prio.val", pc, 8'h31);
    go("hold", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    check("hold.val", pc, 8'h31);

    for (int n = 0; n < 3000; n++) begin
      en         = ($urandom_range(0, 9) != 0);
      pc_load    = ($urandom_range(0, 5) == 0);
      pc_inc     = ($urandom_range(0, 1) == 0);
      branch_rel = ($urandom_range(0, 5) == 0);
      call       = ($urandom_range(0, 4) == 0);
      ret        = ($urandom_range(0, 5) == 0);
      load_addr  = 8'($urandom);
      rel_offset = 8'($urandom);
      step("rnd");
      if ($urandom_range(0, 299) == 0) mid_reset("rndrst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the microprocessor fetch stage; successor of the fixed 8-bit load/increment PC.
- Generalises address width and step size.
- Adds PC-relative branch, absolute load, and a hardware call/return stack of configurable depth with overflow/underflow detection.
- Drives the instruction-memory address; commands come from the control unit, one per cycle.

Parameters:
ADDR_W, 8, PC and address width in bits
STACK_DEPTH, 4, number of return-address entries (>=2)
RESET_ADDR, 0, PC value after reset
INC_STEP, 1, increment applied by pc_inc and stored as call return offset
TRAP_ADDR, 8'hFF (ADDR_W bits), trap vector; used only when PC_TRAP_EN is defined

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global advance enable; 0 = PC and stack frozen, commands ignored
pc_load  in  1  absolute jump to load_addr
load_addr  in  ADDR_W  jump target
pc_inc  in  1  PC <= PC + INC_STEP
branch_rel  in  1  PC <= PC + rel_offset
rel_offset  in  ADDR_W  two's-complement signed offset
call  in  1  push PC+INC_STEP, jump to load_addr
ret  in  1  pop stack into PC
pc  out  ADDR_W  current program counter (registered)
sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  out  1  sp == STACK_DEPTH
stack_empty  out  1  sp == 0
stack_err  out  1  sticky overflow/underflow flag
trap  out  1  one-cycle pulse on trap entry (PC_TRAP_EN only, else constant 0)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_ADDR, sp=0, stack contents don't-care, stack_err=0, trap=0. Takes effect immediately, regardless of clock; a command in flight is discarded. First update on the first rising edge after rst_n rises.
- Output pc is registered: a command sampled at edge N is visible on pc after edge N.
- en=0: hold everything; stack_err stays; trap=0.
- Command priority when several are asserted with en=1: ret > call > pc_load > branch_rel > pc_inc > hold. Only the winner acts; the others are ignored with no error.
- Arithmetic: all PC sums modulo 2^ADDR_W; silent wrap. Example: 8'hFF + 1 = 8'h00, and 8'h02 + 8'hFC (-4) = 8'hFE.
- call, sp < STACK_DEPTH: stack[sp] <= pc+INC_STEP (wrapped); sp <= sp+1; pc <= load_addr.
- call, sp == STACK_DEPTH (overflow): no push, sp unchanged, pc unchanged, stack_err <= 1.
- ret, sp > 0: pc <= stack[sp-1]; sp <= sp-1.
- ret, sp == 0 (underflow): pc unchanged, sp stays 0, stack_err <= 1.
- stack_err is cleared only by reset.
- stack_full and stack_empty are combinational decodes of registered sp.
- No state machine beyond the stack pointer. The sequencer is single-state, apart from the trap pulse below.

Optional Feature:
PC_TRAP_EN
- Defined: an overflow or underflow event forces pc <= TRAP_ADDR on the same edge instead of holding. trap=1 for exactly the following cycle. sp and stack are unchanged as above, and stack_err is still set.
- Not defined: pc holds on error as specified; trap tied 0; TRAP_ADDR unused.

Test Plan:
- Reset with RESET_ADDR=8'h10, then pc_inc for 3 cycles -> pc 10,11,12,13. Assert rst_n=0 mid-cycle -> pc=8'h10 immediately, sp=0.
- pc=8'hFE, pc_inc x2 -> 8'hFF, 8'h00. At pc=8'h02, branch_rel rel_offset=8'hFC -> pc=8'hFE.
- From pc=8'h20: call load_addr=8'h40 -> pc=40, sp=1. Then call 8'h60 -> pc=60, sp=2. Then ret -> pc=41, then ret -> pc=21, sp=0, stack_empty=1.
- Depth 4: five consecutive calls -> fifth leaves pc and sp=4 unchanged, stack_full=1, stack_err=1. With PC_TRAP_EN: pc=TRAP_ADDR and trap pulses once.
- ret with sp=0 -> pc unchanged, stack_err=1 and sticky through later valid commands until reset.
- ret+call+pc_load+pc_inc together with sp=1 -> only ret acts. en=0 with pc_inc -> pc holds.
